// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter: round-robin two-master arbiter for the picorv32 native memory bus
// with registered request/response paths and a watchdog that completes hung slave cycles.
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic        grant_owner,
  output logic        timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic s_valid_q, s_valid_d, s_instr_q, s_instr_d;
  logic [31:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [3:0] s_wstrb_q, s_wstrb_d;
  logic m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic last_q, last_d, owner_q, owner_d, terr_q, terr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic win, expire;
  logic [31:0] resp_data;
  // Contention goes to whoever did not win last; a lone requester always wins.
  assign win = (m0_mem_valid && m1_mem_valid) ? ~last_q : m1_mem_valid;
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign resp_data = s_mem_ready ? s_mem_rdata : ERR_RDATA;
  always_comb begin
    state_d = state_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_addr_d = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    last_d = last_q;
    owner_d = owner_q;
    terr_d = terr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (m0_mem_valid || m1_mem_valid) begin
        s_valid_d = 1'b1;
        s_instr_d = win ? m1_mem_instr : m0_mem_instr;
        s_addr_d = win ? m1_mem_addr : m0_mem_addr;
        s_wdata_d = win ? m1_mem_wdata : m0_mem_wdata;
        s_wstrb_d = win ? m1_mem_wstrb : m0_mem_wstrb;
        owner_d = win;
        last_d = win;
        cnt_d = '0;
        state_d = BUSY;
      end
      BUSY: if (s_mem_ready || expire) begin
        s_valid_d = 1'b0;
        m0_ready_d = ~owner_q;
        m1_ready_d = owner_q;
        m0_rdata_d = owner_q ? m0_rdata_q : resp_data;
        m1_rdata_d = owner_q ? resp_data : m1_rdata_q;
        terr_d = terr_q | ~s_mem_ready;
        state_d = RESP;
      end else begin
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_valid_q <= 1'b0;
      s_instr_q <= 1'b0;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      terr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      last_q <= last_d;
      owner_q <= owner_d;
      terr_q <= terr_d;
      cnt_q <= cnt_d;
    end
  end
  assign s_mem_valid = s_valid_q;
  assign s_mem_instr = s_instr_q;
  assign s_mem_addr = s_addr_q;
  assign s_mem_wdata = s_wdata_q;
  assign s_mem_wstrb = s_wstrb_q;
  assign m0_mem_ready = m0_ready_q;
  assign m1_mem_ready = m1_ready_q;
  assign m0_mem_rdata = m0_rdata_q;
  assign m1_mem_rdata = m1_rdata_q;
  assign grant_owner = owner_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb_picorv32_mem_arbiter: directed vector table, hand-written reset/stale-ready sequences and a
// randomized round-robin transaction model against a behavioural slave.
module tb_picorv32_mem_arbiter;
  logic clk, reset;
  logic m0_mem_valid, m0_mem_instr, m0_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0] m0_mem_wstrb;
  logic m1_mem_valid, m1_mem_instr, m1_mem_ready;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0] m1_mem_wstrb;
  logic s_mem_valid, s_mem_instr, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0] s_mem_wstrb;
  logic grant_owner, timeout_err;
  int checks = 0, errors = 0;
  int n0 = 0, n1 = 0;
  logic mlast = 1'b1;
  int sl_wait = 0, wcnt = 0;
  logic sl_hang = 1'b0, sl_force = 1'b0;
  logic [31:0] sl_data = '0;
  typedef struct {
    logic v0, v1, i0, i1;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0] s0, s1;
    int wt;
    logic hang;
    logic [31:0] sd;
    logic eo;
    logic [31:0] er;
    int el;
  } txn_t;
  txn_t tbl[8];

  picorv32_mem_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready),
    .s_mem_rdata(s_mem_rdata),
    .grant_owner(grant_owner), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave: answers after sl_wait extra cycles unless hung; rdata is junk when not ready.
  always @(negedge clk) begin
    if (s_mem_valid) begin
      s_mem_ready = sl_force | (!sl_hang && wcnt == sl_wait);
      wcnt = wcnt + 1;
    end else begin
      s_mem_ready = sl_force;
      wcnt = 0;
    end
    s_mem_rdata = s_mem_ready ? sl_data : $urandom;
  end

  function automatic void chk(string n, logic [69:0] a, logic [69:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endfunction

  task automatic run_txn(input txn_t t);
    logic ei;
    logic [31:0] ea, ed;
    logic [3:0] es;
    bit done;
    m0_mem_valid = t.v0; m0_mem_instr = t.i0; m0_mem_addr = t.a0; m0_mem_wdata = t.d0; m0_mem_wstrb = t.s0;
    m1_mem_valid = t.v1; m1_mem_instr = t.i1; m1_mem_addr = t.a1; m1_mem_wdata = t.d1; m1_mem_wstrb = t.s1;
    sl_wait = t.wt; sl_hang = t.hang; sl_data = t.sd;
    ei = t.eo ? t.i1 : t.i0;
    ea = t.eo ? t.a1 : t.a0;
    ed = t.eo ? t.d1 : t.d0;
    es = t.eo ? t.s1 : t.s0;
    mlast = t.eo;
    @(negedge clk);
    chk("grant_fields", {s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb}, {1'b1, ei, ea, ed, es});
    chk("grant_owner", 70'(grant_owner), 70'(t.eo));
    done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (m0_mem_ready || m1_mem_ready) begin
        done = 1;
        chk("latency", 70'(k), 70'(t.el));
        chk("ready_who", {68'd0, m1_mem_ready, m0_mem_ready}, t.eo ? 70'd2 : 70'd1);
        chk("rdata", 70'(t.eo ? m1_mem_rdata : m0_mem_rdata), 70'(t.er));
        chk("s_valid_drop", 70'(s_mem_valid), 70'd0);
        if (t.eo) begin m1_mem_valid = 1'b0; n1++; end
        else begin m0_mem_valid = 1'b0; n0++; end
      end else begin
        chk("hold", {s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb}, {1'b1, ei, ea, ed, es});
      end
    end
    if (!done) chk("ready_timeout", 70'd0, 70'd1);
    @(negedge clk);
    chk("ready_pulse", {68'd0, m1_mem_ready, m0_mem_ready}, 70'd0);
  endtask

  initial begin
    txn_t t;
    logic p [2];
    logic pi [2];
    logic [31:0] pa [2], pd [2];
    logic [3:0] ps [2];
    logic w;
    // {v0,v1,i0,i1,a0,a1,d0,d1,s0,s1,wait,hang,slave data,exp owner,exp rdata,exp latency}
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 32'h2222_0000, 4'h0, 4'hF, 0, 1'b0, 32'hAAAA_0001, 1'b0, 32'hAAAA_0001, 1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h20, 32'h0, 32'h2222_0000, 4'h0, 4'hF, 1, 1'b0, 32'hAAAA_0002, 1'b1, 32'hAAAA_0002, 2};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h24, 32'h0, 32'h2222_0004, 4'h0, 4'h3, 0, 1'b0, 32'hAAAA_0003, 1'b0, 32'hAAAA_0003, 1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h18, 32'h24, 32'h0, 32'h2222_0004, 4'h0, 4'h3, 2, 1'b0, 32'hAAAA_0004, 1'b1, 32'hAAAA_0004, 3};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'hA5A5_0F0F, 4'h0, 4'b0110, 3, 1'b0, 32'h5555_5555, 1'b1, 32'h5555_5555, 4};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 1'b1, 32'h7777_7777, 1'b0, 32'hDEAD_BEEF, 8};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h400, 32'h0, 32'h0, 4'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 2};
    reset = 1'b1;
    {m0_mem_valid, m0_mem_instr, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb} = '0;
    {m1_mem_valid, m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb} = '0;
    repeat (3) @(negedge clk);
    chk("rst_slave", {s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb}, 70'd0);
    chk("rst_master", {4'd0, m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata}, 70'd0);
    chk("rst_owner_terr", {68'd0, grant_owner, timeout_err}, 70'd0);
    reset = 1'b0;
    mlast = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
      if (i == 3) chk("contention_pulses", {35'(n0), 35'(n1)}, {35'd2, 35'd2});
      if (i >= 6) chk("timeout_sticky", 70'(timeout_err), 70'd1);
      if (i < 6) chk("no_timeout", 70'(timeout_err), 70'd0);
    end
    // Stale slave ready while idle must not produce any response or leave IDLE.
    sl_force = 1'b1;
    @(negedge clk);
    sl_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stale_ready", {67'd0, s_mem_valid, m0_mem_ready, m1_mem_ready}, 70'd0);
      @(negedge clk);
    end
    t = tbl[4];
    t.sd = 32'h0F0F_1234;
    t.er = 32'h0F0F_1234;
    run_txn(t);
    // Randomized traffic: a pending loser keeps its request; the model decides grants by fairness rule.
    p[0] = 1'b0;
    p[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p[m] && $urandom_range(1, 0) == 1) begin
          p[m] = 1'b1; pi[m] = 1'($urandom); pa[m] = $urandom; pd[m] = $urandom; ps[m] = 4'($urandom);
        end
      end
      if (!p[0] && !p[1]) begin
        p[0] = 1'b1; pi[0] = 1'($urandom); pa[0] = $urandom; pd[0] = $urandom; ps[0] = 4'($urandom);
      end
      w = (p[0] && p[1]) ? !mlast : p[1];
      t.v0 = p[0]; t.i0 = pi[0]; t.a0 = pa[0]; t.d0 = pd[0]; t.s0 = ps[0];
      t.v1 = p[1]; t.i1 = pi[1]; t.a1 = pa[1]; t.d1 = pd[1]; t.s1 = ps[1];
      t.wt = int'($urandom_range(3, 0));
      t.hang = 1'b0;
      t.sd = $urandom;
      t.er = t.sd;
      t.eo = w;
      t.el = t.wt + 1;
      run_txn(t);
      p[w] = 1'b0;
    end
    // Reset while a hung transaction is in flight: m0 won last, yet after reset m0 must win again.
    @(negedge clk);
    m0_mem_valid = 1'b1; m0_mem_addr = 32'h500; m0_mem_wstrb = 4'h0;
    m1_mem_valid = 1'b0;
    sl_hang = 1'b1;
    @(negedge clk);
    chk("busy_before_reset", {69'd0, s_mem_valid}, 70'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_slave", {s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb}, 70'd0);
    chk("async_rst_master", {4'd0, m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata}, 70'd0);
    chk("async_rst_terr", {68'd0, grant_owner, timeout_err}, 70'd0);
    m0_mem_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_no_ready", {68'd0, m0_mem_ready, m1_mem_ready}, 70'd0);
    end
    reset = 1'b0;
    t = tbl[0];
    t.sd = 32'hC0DE_0001;
    t.er = 32'hC0DE_0001;
    run_txn(t);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
